// File: rtl/audio_sample_fifo_pkg.sv
// audio_fifo_pkg: shared types and constants for the audio sample FIFO.
//   fill_state_e  - prefill controller states (FILL/RUN)
//   level_width() - bit width needed to hold a level of 0..depth
//   DEF_*         - default parameter values
package audio_fifo_pkg;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_CHANNELS = 2;
  localparam int DEF_DEPTH    = 8;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } fill_state_e;

  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/audio_sample_fifo_if.sv
// audio_sample_fifo_if: sample-path signals between the producer/packetiser and the FIFO.
//   in_valid     - one-cycle write strobe
//   in_data      - input frame, CHANNELS*WIDTH bits, channel 0 in the LSBs
//   audio_sample - one-cycle read strobe from the packetiser
//   out_data     - registered output frame
// Modports: master (bench/producer side), slave (FIFO side).
interface audio_sample_fifo_if
  import audio_fifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS
);

  logic                      in_valid;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic                      audio_sample;
  logic [CHANNELS*WIDTH-1:0] out_data;

  modport master (output in_valid, output in_data, output audio_sample, input out_data);
  modport slave  (input in_valid, input in_data, input audio_sample, output out_data);

endinterface

// File: rtl/audio_fifo_ram.sv
// audio_fifo_ram: simple dual-port RAM, DEPTH x DW, synchronous write.
// The read register holds its value unless re or load is asserted; it is
// also the block's output register, so load lets pass-through frames land
// in it directly.
//   clk, reset_n     - clock, async active-low reset (clears rdata only)
//   we, waddr, wdata - write port
//   re, raddr        - read port, rdata updates the cycle after re
//   load, load_data  - direct load of rdata, takes priority over re
//   rdata            - registered read data
module audio_fifo_ram #(
  parameter int DW    = 32,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read-before-write on a shared address: a full FIFO reading and writing
  // the same slot gets the old frame, which is the one it should output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  rdata <= '0;
    else if (load) rdata <= load_data;
    else if (re)   rdata <= mem[raddr];
  end

endmodule

// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo: multi-channel audio sample buffer in the HDMI pixel clock domain.
//   clk, reset_n  - pixel clock, async active-low reset
//   enable        - 1: FIFO mode, 0: pass-through (FIFO flushed, out_data follows in_valid)
//   clear_flags   - clears overflow/underflow; a same-cycle set wins
//   bus (slave)   - in_valid/in_data writes, audio_sample reads, out_data
//   level         - stored entries, 0..DEPTH
//   overflow      - sticky, a write was dropped on a full FIFO
//   underflow     - sticky, a read found the FIFO empty (out_data held)
// Build option: AUDIO_FIFO_PREFILL_EN adds a FILL/RUN controller that blocks
// reads until the FIFO is half full; without it the block is always in RUN.
//
// state | meaning
// FILL  | collecting frames, audio_sample ignored until level >= DEPTH/2
// RUN   | reads served; an underflow returns to FILL
module audio_sample_fifo
  import audio_fifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int DEPTH    = DEF_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic                          clear_flags,
  audio_sample_fifo_if.slave            bus,
  output logic [level_width(DEPTH)-1:0] level,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int FW = CHANNELS * WIDTH;
  localparam int LW = level_width(DEPTH);
  localparam int PW = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] HALF_LVL = LW'(DEPTH / 2);

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [FW-1:0] out_q;
  logic          in_run, empty, full;
  logic          rd_req, rd_acc, wr_acc, ovf_evt, udf_evt;

  assign empty = (level == '0);
  assign full  = (level == FULL_LVL);

  assign rd_req  = enable & in_run & bus.audio_sample;
  assign rd_acc  = rd_req & ~empty;
  assign udf_evt = rd_req & empty;
  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign wr_acc  = enable & bus.in_valid & (~full | rd_acc);
  assign ovf_evt = enable & bus.in_valid & full & ~rd_acc;

`ifdef AUDIO_FIFO_PREFILL_EN
  fill_state_e state, state_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= FILL;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = FILL;
    end else begin
      case (state)
        FILL:    if (level >= HALF_LVL) state_nxt = RUN;
        RUN:     if (udf_evt)           state_nxt = FILL;
        default: state_nxt = FILL;
      endcase
    end
  end

  assign in_run = (state == RUN);
`else
  assign in_run = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (!enable) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
      level <= level + LW'(wr_acc) - LW'(rd_acc);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_evt)          overflow  <= 1'b1;
      else if (clear_flags) overflow  <= 1'b0;
      if (udf_evt)          underflow <= 1'b1;
      else if (clear_flags) underflow <= 1'b0;
    end
  end

  audio_fifo_ram #(
    .DW    (FW),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_ram (
    .clk       (clk),
    .reset_n   (reset_n),
    .we        (wr_acc),
    .waddr     (wr_ptr),
    .wdata     (bus.in_data),
    .re        (rd_acc),
    .raddr     (rd_ptr),
    .load      (~enable & bus.in_valid),
    .load_data (bus.in_data),
    .rdata     (out_q)
  );

  assign bus.out_data = out_q;

endmodule

// File: tb/tb_audio_sample_fifo.sv
// tb_audio_sample_fifo: directed bench for audio_sample_fifo (WIDTH=16, CHANNELS=2, DEPTH=8).
// A queue-based model tracks frames, output, flags (and prefill state when
// AUDIO_FIFO_PREFILL_EN is defined); a compare process checks every cycle,
// and directed sections pin hand-computed values.
module tb_audio_sample_fifo;

  localparam int WIDTH    = 16;
  localparam int CHANNELS = 2;
  localparam int DEPTH    = 8;
  localparam int FW       = WIDTH * CHANNELS;
  localparam int LW       = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b1;
  logic          clear_flags = 1'b0;
  logic [LW-1:0] level;
  logic          overflow, underflow;

  audio_sample_fifo_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus ();

  audio_sample_fifo #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .clear_flags (clear_flags),
    .bus         (bus),
    .level       (level),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [FW-1:0] mq[$];
  logic [FW-1:0] m_out = '0;
  bit            m_ovf = 1'b0;
  bit            m_udf = 1'b0;
`ifdef AUDIO_FIFO_PREFILL_EN
  bit            m_fill = 1'b1;
`endif

  task automatic model_step();
    int n;
    bit ovf_e, udf_e, rd_ok, run;
    n = mq.size();
    ovf_e = 1'b0; udf_e = 1'b0; rd_ok = 1'b0; run = 1'b1;
    if (!enable) begin
      mq.delete();
      if (bus.in_valid) m_out = bus.in_data;
`ifdef AUDIO_FIFO_PREFILL_EN
      m_fill = 1'b1;
`endif
    end else begin
`ifdef AUDIO_FIFO_PREFILL_EN
      run = !m_fill;
`endif
      if (run && bus.audio_sample) begin
        if (n == 0) udf_e = 1'b1;
        else begin
          m_out = mq.pop_front();
          rd_ok = 1'b1;
        end
      end
      if (bus.in_valid) begin
        if (n < DEPTH || rd_ok) mq.push_back(bus.in_data);
        else ovf_e = 1'b1;
      end
`ifdef AUDIO_FIFO_PREFILL_EN
      if (m_fill) m_fill = !(n >= DEPTH / 2);
      else if (udf_e) m_fill = 1'b1;
`endif
    end
    m_ovf = ovf_e ? 1'b1 : (clear_flags ? 1'b0 : m_ovf);
    m_udf = udf_e ? 1'b1 : (clear_flags ? 1'b0 : m_udf);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        mq.delete();
        m_out = '0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
`ifdef AUDIO_FIFO_PREFILL_EN
        m_fill = 1'b1;
`endif
      end else begin
        model_step();
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        total++;
        if (bus.out_data !== m_out || level !== LW'(mq.size()) ||
            overflow !== m_ovf || underflow !== m_udf) begin
          bad++;
          $display("FAIL model t=%0t: out=%h lvl=%0d ovf=%b udf=%b, want out=%h lvl=%0d ovf=%b udf=%b",
                   $time, bus.out_data, level, overflow, underflow,
                   m_out, mq.size(), m_ovf, m_udf);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic cyc(input bit v, input logic [FW-1:0] d, input bit rd, input bit clr);
    bus.in_valid     = v;
    bus.in_data      = d;
    bus.audio_sample = rd;
    clear_flags      = clr;
    @(negedge clk);
    bus.in_valid     = 1'b0;
    bus.audio_sample = 1'b0;
    clear_flags      = 1'b0;
  endtask

  initial begin
    bus.in_valid     = 1'b0;
    bus.in_data      = '0;
    bus.audio_sample = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    chk("reset_out", bus.out_data, 32'h0);
    chk("reset_level", 32'(level), 32'd0);
    chk("reset_ovf", 32'(overflow), 32'd0);
    chk("reset_udf", 32'(underflow), 32'd0);
    cyc(0, '0, 0, 0);

`ifndef AUDIO_FIFO_PREFILL_EN
    // basic ordering
    cyc(1, 32'h0001_0002, 0, 0);
    cyc(1, 32'h0003_0004, 0, 0);
    cyc(1, 32'h0005_0006, 0, 0);
    chk("basic_level3", 32'(level), 32'd3);
    cyc(0, '0, 1, 0);
    chk("basic_rd0", bus.out_data, 32'h0001_0002);
    cyc(0, '0, 1, 0);
    chk("basic_rd1", bus.out_data, 32'h0003_0004);
    cyc(0, '0, 1, 0);
    chk("basic_rd2", bus.out_data, 32'h0005_0006);
    chk("basic_level0", 32'(level), 32'd0);

    // overflow: frame 8 dropped
    for (int i = 0; i < 9; i++) cyc(1, FW'(i), 0, 0);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_level", 32'(level), 32'd8);
    for (int i = 0; i < 8; i++) begin
      cyc(0, '0, 1, 0);
      chk("ovf_order", bus.out_data, 32'(i));
    end
    cyc(0, '0, 1, 0);
    chk("ovf_no_frame8", bus.out_data, 32'd7);
    chk("ovf_then_udf", 32'(underflow), 32'd1);
    cyc(0, '0, 0, 1);
    chk("ovf_clear", 32'(overflow), 32'd0);

    // underflow holds last sample
    cyc(1, 32'hAAAA_5555, 0, 0);
    cyc(0, '0, 1, 0);
    chk("udf_read", bus.out_data, 32'hAAAA_5555);
    cyc(0, '0, 1, 0);
    chk("udf_hold", bus.out_data, 32'hAAAA_5555);
    chk("udf_flag", 32'(underflow), 32'd1);
    cyc(0, '0, 0, 1);
    chk("udf_clear", 32'(underflow), 32'd0);

    // simultaneous read+write on full, then on empty
    for (int i = 0; i < 8; i++) cyc(1, FW'(32'h100 + i), 0, 0);
    cyc(1, 32'h0000_BEEF, 1, 0);
    chk("full_rw_level", 32'(level), 32'd8);
    chk("full_rw_ovf", 32'(overflow), 32'd0);
    chk("full_rw_out", bus.out_data, 32'h100);
    for (int i = 1; i < 8; i++) cyc(0, '0, 1, 0);
    chk("full_rw_drain7", bus.out_data, 32'h107);
    cyc(0, '0, 1, 0);
    chk("full_rw_beef", bus.out_data, 32'h0000_BEEF);
    cyc(1, 32'h0000_1234, 1, 0);
    chk("empty_rw_udf", 32'(underflow), 32'd1);
    chk("empty_rw_level", 32'(level), 32'd1);
    cyc(0, '0, 1, 1);
    chk("clr_plain_udf", 32'(underflow), 32'd0);
    chk("clr_plain_out", bus.out_data, 32'h0000_1234);
    cyc(0, '0, 1, 1);
    chk("set_beats_clear", 32'(underflow), 32'd1);
    cyc(0, '0, 0, 1);

    // pass-through
    for (int i = 0; i < 5; i++) cyc(1, FW'(32'h50 + i), 0, 0);
    chk("pt_level5", 32'(level), 32'd5);
    enable = 1'b0;
    cyc(0, '0, 0, 0);
    chk("pt_flush", 32'(level), 32'd0);
    cyc(1, 32'hCAFE_F00D, 0, 0);
    chk("pt_follow0", bus.out_data, 32'hCAFE_F00D);
    cyc(0, '0, 0, 0);
    chk("pt_hold", bus.out_data, 32'hCAFE_F00D);
    cyc(1, 32'h1111_2222, 1, 0);
    chk("pt_follow1", bus.out_data, 32'h1111_2222);
    chk("pt_rd_ignored", 32'(underflow), 32'd0);
    enable = 1'b1;
    cyc(0, '0, 1, 0);
    chk("reen_empty_udf", 32'(underflow), 32'd1);
    chk("reen_out_hold", bus.out_data, 32'h1111_2222);
    cyc(0, '0, 0, 1);
`else
    // prefill: reads ignored while filling, first read one cycle after level=4 is seen
    for (int i = 0; i < 3; i++) begin
      cyc(1, FW'(32'h700 + i), 1, 0);
      chk("pf_level", 32'(level), 32'(i + 1));
      chk("pf_out", bus.out_data, 32'h0);
      chk("pf_no_udf", 32'(underflow), 32'd0);
    end
    cyc(1, 32'h703, 0, 0);
    chk("pf_level4", 32'(level), 32'd4);
    cyc(0, '0, 1, 0);
    chk("pf_still_fill", bus.out_data, 32'h0);
    chk("pf_level4b", 32'(level), 32'd4);
    cyc(0, '0, 1, 0);
    chk("pf_first_rd", bus.out_data, 32'h700);
    chk("pf_level3", 32'(level), 32'd3);
    cyc(0, '0, 1, 0);
    chk("pf_second_rd", bus.out_data, 32'h701);
`endif

    repeat (2) cyc(0, '0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
